fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter register and instruction-fetch sequencer; sits directly upstream of the PC adder.
- Drives the current PC to the adder (pc_o to adder a; b tied to 32'd4) and consumes the adder sum as the sequential next PC.
- Fetches one instruction at a time over a req/gnt/rvalid instruction-memory port.
- Presents each fetched instruction to decode with a valid/ready handshake and accepts branch/jump redirects.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  system clock, all state rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pc_o  out  XLEN  current PC (pc_q), feeds adder input a.
- pc_plus4_i  in  XLEN  adder sum, used verbatim as the sequential next PC.
- redirect_i  in  1  single-cycle pulse: load redirect_target_i as the new PC.
- redirect_target_i  in  XLEN  branch/jump target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  fetch address (= pc_q).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid; exactly one per granted request, earliest the cycle after gnt.
- imem_rdata_i  in  XLEN  instruction word.
- instr_valid_o  out  1  instruction buffer holds a valid instruction.
- instr_o  out  XLEN  buffered instruction.
- instr_pc_o  out  XLEN  PC of the buffered instruction.
- instr_ready_i  in  1  decode accepts the instruction.
- fetch_misalign_o  out  1  sticky: PC not word-aligned; fetching halted.

Behaviour:
- Reset (rst_n low, async):
  - pc_q=RESET_PC, state=IDLE, kill_q=0.
  - imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_misalign_o=0.
  - The instruction memory shares rst_n; no response survives reset.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: outputs idle; unconditionally goes to REQ next cycle.
- REQ:
  - imem_req_o=1, imem_addr_o=pc_q.
  - Request and address held stable until imem_gnt_i.
  - On gnt, go to WAIT.
- WAIT:
  - On rvalid with kill_q=0: instr_o<=rdata, instr_pc_o<=pc_q, pc_q<=pc_plus4_i, go to HOLD.
  - On rvalid with kill_q=1: discard the response, kill_q<=0, go to REQ.
- HOLD:
  - instr_valid_o=1; instr_o and instr_pc_o stable.
  - On instr_ready_i, go to REQ next cycle.
- Timing:
  - Zero-wait memory (gnt in the REQ cycle, rvalid the next cycle) gives first instr_valid_o 3 cycles after IDLE exits (REQ, WAIT, HOLD).
  - Steady-state throughput is 1 instruction per 3 cycles with ready held high.
- Redirect (highest priority, any state):
  - pc_q<=redirect_target_i.
  - If target[1:0]!=0: fetch_misalign_o<=1, go to FAULT; no request issued; any in-flight response is still drained and discarded (kill_q set).
  - IDLE: go to REQ.
  - REQ with no gnt the same cycle: stay in REQ; the address switches to the target next cycle.
  - REQ with gnt the same cycle: go to WAIT, kill_q<=1 (old-address response is dropped).
  - WAIT with no rvalid the same cycle: kill_q<=1, stay in WAIT.
  - WAIT with rvalid the same cycle: discard the response, go to REQ.
  - HOLD: instr_valid_o=0 next cycle, go to REQ. If instr_ready_i is also high that cycle, the transfer counts as completed.
- FAULT:
  - imem_req_o=0, instr_valid_o=0.
  - Stays in FAULT until a redirect with an aligned target, which clears fetch_misalign_o and goes to REQ.
  - A misaligned redirect re-loads pc_q and stays in FAULT.
  - If kill_q is set, one rvalid may still arrive; it is ignored and clears kill_q.
- Width rules:
  - pc_plus4_i is taken as-is; wrap from 32'hFFFF_FFFC to 0 is permitted and not flagged.
  - The redirect target is never modified (bits [1:0] are not masked).

Test Plan:
- Reset release, zero-wait memory, ready=1:
  - Required response: pc_o=0x8000_0000, then imem_addr_o=0x8000_0000, 0x8000_0004, 0x8000_0008 at 3-cycle spacing.
  - instr_pc_o values match the addresses, and instr_o equals the returned data.
- Backpressure: ready=0 for 5 cycles in HOLD -> instr_valid_o held high, instr_o stable, no imem_req_o; ready=1 -> next request at pc+4.
- Redirect to 0x8000_0100 in the same cycle as gnt for 0x8000_0008 -> that response is discarded, the next request is 0x8000_0100, and no instr_valid_o is produced for 0x8000_0008.
- Redirect in HOLD with instr_ready_i=0 -> instr_valid_o drops the next cycle and the next fetch is at the target.
- Redirect to 0x8000_0102 -> fetch_misalign_o=1 and imem_req_o stays 0; a later redirect to 0x8000_0200 -> flag clears and a request is issued at 0x8000_0200.
- Assert rst_n low during WAIT -> all outputs are immediately at reset values; after release, fetch resumes at 0x8000_0000.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Drives pc_q to the external PC adder and takes its sum back as the next PC.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | one idle cycle after reset, then start fetching
// REQ   | imem_req_o high at pc_q, waiting for imem_gnt_i
// WAIT  | request granted, waiting for imem_rvalid_i
// HOLD  | instruction buffered, instr_valid_o high until decode takes it
// FAULT | misaligned redirect target; fetch halted until aligned redirect
module fetch_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fetch_misalign_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            kill_q, kill_d;
  logic            mis_q, mis_d;
  logic            tgt_misaligned;

  assign tgt_misaligned = (redirect_target_i[1:0] != 2'b00);

  // State and datapath registers; nothing survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and next-value logic; redirect overrides the normal flow last.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    ipc_d         = ipc_q;
    kill_d        = kill_q;
    mis_d         = mis_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        // A stale response left over from FAULT may land here; it only clears the kill.
        if (imem_rvalid_i && kill_q) kill_d = 1'b0;
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d = imem_rdata_i;
            ipc_d   = pc_q;
            pc_d    = pc_plus4_i;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) state_d = REQ;
      end
      FAULT: begin
        if (imem_rvalid_i && kill_q) kill_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      pc_d    = redirect_target_i;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      if (tgt_misaligned) begin
        mis_d   = 1'b1;
        state_d = FAULT;
        // Keep a kill pending for any response still owed by the memory.
        kill_d  = (state_q == REQ && imem_gnt_i) ||
                  (state_q == WAIT && !imem_rvalid_i) ||
                  (state_q != WAIT && kill_q && !imem_rvalid_i);
      end else begin
        mis_d = 1'b0;
        unique case (state_q)
          REQ: begin
            if (imem_gnt_i) begin
              state_d = WAIT;
              kill_d  = 1'b1;
            end else begin
              state_d = REQ;
            end
          end
          WAIT: begin
            if (imem_rvalid_i) begin
              state_d = REQ;
              kill_d  = 1'b0;
            end else begin
              state_d = WAIT;
              kill_d  = 1'b1;
            end
          end
          default: state_d = REQ;
        endcase
      end
    end
  end

  assign pc_o             = pc_q;
  assign imem_addr_o      = pc_q;
  assign instr_o          = instr_q;
  assign instr_pc_o       = ipc_q;
  assign fetch_misalign_o = mis_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: per-cycle vector table plus hand sequences
// for reset during WAIT and a misaligned redirect with a response in flight.
module tb_fetch_pc_unit;

  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk, rst_n;
  logic [31:0] pc_o, pc_plus4, redirect_target, imem_addr, imem_rdata;
  logic [31:0] instr, instr_pc;
  logic        redirect, imem_req, imem_gnt, imem_rvalid;
  logic        instr_valid, instr_ready, fetch_misalign, gnt_en;
  logic [31:0] pend_addr;

  fetch_pc_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_o              (pc_o),
    .pc_plus4_i        (pc_plus4),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .imem_req_o        (imem_req),
    .imem_addr_o       (imem_addr),
    .imem_gnt_i        (imem_gnt),
    .imem_rvalid_i     (imem_rvalid),
    .imem_rdata_i      (imem_rdata),
    .instr_valid_o     (instr_valid),
    .instr_o           (instr),
    .instr_pc_o        (instr_pc),
    .instr_ready_i     (instr_ready),
    .fetch_misalign_o  (fetch_misalign)
  );

  // PC adder and zero-wait memory: data = address ^ KEY, one cycle after gnt.
  assign pc_plus4   = pc_o + 32'd4;
  assign imem_gnt   = imem_req && gnt_en;
  assign imem_rdata = pend_addr ^ KEY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      pend_addr   <= '0;
    end else begin
      imem_rvalid <= imem_req && imem_gnt;
      pend_addr   <= imem_addr;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        rdy;
    logic        gnt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cur    = -1;

  function automatic vec_t v(logic rd, logic [31:0] t, logic rdy, logic g,
                             logic rq, logic [31:0] a, logic vl, logic [31:0] ip, logic m);
    vec_t r;
    r = '{rd, t, rdy, g, rq, a, vl, ip, m};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %h, expected %h", name, cur, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_state(input logic rq, input logic [31:0] a, input logic vl,
                           input logic [31:0] ip, input logic m);
    chk("imem_req", {31'd0, imem_req}, {31'd0, rq});
    chk("pc/addr", imem_addr, a);
    chk("pc_o", pc_o, a);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, vl});
    chk("misalign", {31'd0, fetch_misalign}, {31'd0, m});
    if (vl) begin
      chk("instr_pc", instr_pc, ip);
      chk("instr", instr, ip ^ KEY);
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_target = '0;
    instr_ready = 1'b1; gnt_en = 1'b1;

    //            rd tgt           rdy g  req addr          vl ipc           mis
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0000, 0, 0,            0)); // IDLE
    vecs.push_back(v(0, 0,            1, 1, 1, 32'h8000_0000, 0, 0,            0)); // REQ
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0000, 0, 0,            0)); // WAIT
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0004, 1, 32'h8000_0000, 0)); // HOLD
    vecs.push_back(v(0, 0,            1, 1, 1, 32'h8000_0004, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0004, 0, 0,            0));
    for (int i = 0; i < 5; i++)                                                     // backpressure
      vecs.push_back(v(0, 0,          0, 1, 0, 32'h8000_0008, 1, 32'h8000_0004, 0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0008, 1, 32'h8000_0004, 0));
    vecs.push_back(v(1, 32'h8000_0100, 1, 1, 1, 32'h8000_0008, 0, 0,            0)); // redirect+gnt
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0100, 0, 0,            0)); // killed rsp
    vecs.push_back(v(0, 0,            1, 1, 1, 32'h8000_0100, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0100, 0, 0,            0));
    vecs.push_back(v(1, 32'h8000_0040, 0, 1, 0, 32'h8000_0104, 1, 32'h8000_0100, 0)); // HOLD redirect
    vecs.push_back(v(0, 0,            1, 1, 1, 32'h8000_0040, 0, 0,            0));
    vecs.push_back(v(0, 0,            0, 1, 0, 32'h8000_0040, 0, 0,            0));
    vecs.push_back(v(1, 32'h8000_0102, 0, 1, 0, 32'h8000_0044, 1, 32'h8000_0040, 0)); // misalign
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0102, 0, 0,            1));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0102, 0, 0,            1));
    vecs.push_back(v(1, 32'h8000_0200, 1, 1, 0, 32'h8000_0102, 0, 0,            1));
    vecs.push_back(v(0, 0,            1, 1, 1, 32'h8000_0200, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0200, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0204, 1, 32'h8000_0200, 0));
    vecs.push_back(v(0, 0,            1, 0, 1, 32'h8000_0204, 0, 0,            0)); // no gnt
    vecs.push_back(v(1, 32'h8000_0300, 1, 0, 1, 32'h8000_0204, 0, 0,            0)); // redirect, no gnt
    vecs.push_back(v(0, 0,            1, 1, 1, 32'h8000_0300, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h8000_0300, 0, 0,            0));
    vecs.push_back(v(1, 32'hFFFF_FFFC, 1, 1, 0, 32'h8000_0304, 1, 32'h8000_0300, 0)); // ready+redirect
    vecs.push_back(v(0, 0,            1, 1, 1, 32'hFFFF_FFFC, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'hFFFF_FFFC, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0)); // wrap
    vecs.push_back(v(0, 0,            1, 1, 1, 32'h0000_0000, 0, 0,            0));
    vecs.push_back(v(0, 0,            1, 1, 0, 32'h0000_0000, 0, 0,            0)); // WAIT

    // Reset values while rst_n is low.
    #12;
    chk_state(1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
    chk("instr_rst", instr, 32'h0);
    chk("instr_pc_rst", instr_pc, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      cur             = i;
      redirect        = vecs[i].redir;
      redirect_target = vecs[i].tgt;
      instr_ready     = vecs[i].rdy;
      gnt_en          = vecs[i].gnt;
      #1;
      chk_state(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_ipc, vecs[i].e_mis);
    end
    redirect = 1'b0; instr_ready = 1'b1; gnt_en = 1'b1;

    // Async reset while in WAIT: outputs return to reset values at once.
    cur = 100;
    #1 rst_n = 1'b0;
    #1;
    chk_state(1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
    chk("instr_rst2", instr, 32'h0);
    chk("instr_pc_rst2", instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = 101; #1 chk_state(1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    cur = 102; #1 chk_state(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0);

    // Misaligned redirect on the gnt cycle: response drains in FAULT, then recovery.
    redirect = 1'b1; redirect_target = 32'h8000_0403;
    @(negedge clk);
    redirect = 1'b0;
    cur = 103; #1 chk_state(1'b0, 32'h8000_0403, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    cur = 104; #1 chk_state(1'b0, 32'h8000_0403, 1'b0, 32'h0, 1'b1);
    redirect = 1'b1; redirect_target = 32'h8000_0400;
    @(negedge clk);
    redirect = 1'b0;
    cur = 105; #1 chk_state(1'b1, 32'h8000_0400, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    cur = 106; #1 chk_state(1'b0, 32'h8000_0400, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    cur = 107; #1 chk_state(1'b0, 32'h8000_0404, 1'b1, 32'h8000_0400, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
